// File: rtl/mem_arb_pkg.sv
// Shared types for the data-RAM port arbiter: FSM states, port owner encoding, word size.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_PIM
    } owner_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/burst_addr_gen.sv
// Burst address generator: latches base/len, walks word addresses one beat per step.
// Latency: address valid the cycle after load; advances on the cycle after each step.
// Backpressure: none; the caller simply withholds step while the burst is paused.
module burst_addr_gen
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] beat_addr,
    output logic              last,
    output logic [LEN_W-1:0]  beat_idx
);

    logic [LEN_W-1:0] len_q;

    // Address wraps modulo 2^ADDR_W by plain overflow.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            beat_addr <= '0;
            len_q     <= '0;
            beat_idx  <= '0;
        end else if (load) begin
            beat_addr <= base & ~ADDR_W'(WORD_BYTES - 1);
            len_q     <= len;
            beat_idx  <= '0;
        end else if (step) begin
            beat_addr <= beat_addr + ADDR_W'(WORD_BYTES);
            beat_idx  <= beat_idx + 1'b1;
        end
    end

    assign last = (beat_idx == len_q - 1'b1);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port data RAM between CPU single beats and PIM incrementing bursts.
// Latency: CPU grant same cycle when uncontended, load data one cycle later; PIM beat 0 the cycle after request.
// Backpressure: CPU holds cpu_req until cpu_gnt; a burst yields one beat to a waiting CPU every MAX_HOLD beats.
module ram_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              pim_req,
    input  logic              pim_we,
    input  logic [ADDR_W-1:0] pim_addr,
    input  logic [LEN_W-1:0]  pim_len,
    input  logic [DATA_W-1:0] pim_wdata,
    output logic              pim_wready,
    output logic              pim_rvalid,
    output logic [DATA_W-1:0] pim_rdata,
    output logic              pim_done,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_t        state, state_nxt;
    owner_t            owner;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              burst_we;
    logic              ag_load, ag_step, ag_last;
    logic [ADDR_W-1:0] ag_addr;
    logic [LEN_W-1:0]  beat_idx_unused;

    burst_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .CLK       (CLK),
        .RST       (RST),
        .load      (ag_load),
        .step      (ag_step),
        .base      (pim_addr),
        .len       (pim_len),
        .beat_addr (ag_addr),
        .last      (ag_last),
        .beat_idx  (beat_idx_unused)
    );

    // In IDLE the CPU takes the RAM this cycle while a simultaneous burst request is
    // still latched, so beat 0 follows immediately.
    always_comb begin
        state_nxt = state;
        owner     = OWN_NONE;
        hold_nxt  = hold_cnt;
        ag_load   = 1'b0;
        ag_step   = 1'b0;
        pim_done  = 1'b0;
        unique case (state)
            IDLE: begin
                hold_nxt = '0;
                if (cpu_req) owner = OWN_CPU;
                if (pim_req) begin
                    if (pim_len != '0) begin
                        ag_load   = 1'b1;
                        state_nxt = BURST;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            BURST: begin
                if (cpu_req && hold_cnt == HOLD_W'(MAX_HOLD)) begin
                    owner    = OWN_CPU;
                    hold_nxt = '0;
                end else begin
                    owner    = OWN_PIM;
                    ag_step  = 1'b1;
                    hold_nxt = cpu_req ? hold_cnt + 1'b1 : '0;
                    if (ag_last) state_nxt = DONE;
                end
            end
            DONE: begin
                pim_done  = 1'b1;
                hold_nxt  = '0;
                state_nxt = IDLE;
                if (cpu_req) owner = OWN_CPU;
            end
            default: state_nxt = IDLE;
        endcase
        if (RST) begin
            owner    = OWN_NONE;
            pim_done = 1'b0;
        end
    end

    always_comb begin
        ram_a      = '0;
        ram_d      = '0;
        ram_we     = 1'b0;
        cpu_gnt    = 1'b0;
        pim_wready = 1'b0;
        case (owner)
            OWN_CPU: begin
                ram_a   = cpu_addr & ~ADDR_W'(WORD_BYTES - 1);
                ram_d   = cpu_wdata;
                ram_we  = cpu_we;
                cpu_gnt = 1'b1;
            end
            OWN_PIM: begin
                ram_a      = ag_addr;
                ram_d      = pim_wdata;
                ram_we     = burst_we;
                pim_wready = burst_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            burst_we   <= 1'b0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            pim_rvalid <= 1'b0;
            pim_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            if (ag_load) burst_we <= pim_we;
            cpu_rvalid <= cpu_gnt && !cpu_we;
            if (cpu_gnt && !cpu_we) cpu_rdata <= ram_q;
            pim_rvalid <= (owner == OWN_PIM) && !burst_we;
            if ((owner == OWN_PIM) && !burst_we) pim_rdata <= ram_q;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, shadow memory model and expectation queues.
module tb_ram_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        pim_req, pim_we, pim_wready, pim_rvalid, pim_done;
    logic [31:0] pim_addr, pim_wdata, pim_rdata;
    logic [7:0]  pim_len;
    logic [31:0] ram_a, ram_d, ram_q;
    logic        ram_we;

    logic [31:0] mem   [0:1023];
    logic [31:0] model [0:1023];
    logic [63:0] wr_q  [$];
    logic [31:0] cpu_q [$];
    logic [31:0] pim_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 CLK = ~CLK;

    ram_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .LEN_W(8), .MAX_HOLD(16)
    ) dut (
        .CLK(CLK), .RST(RST),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .pim_req(pim_req), .pim_we(pim_we), .pim_addr(pim_addr), .pim_len(pim_len),
        .pim_wdata(pim_wdata), .pim_wready(pim_wready), .pim_rvalid(pim_rvalid),
        .pim_rdata(pim_rdata), .pim_done(pim_done),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
    );

    assign ram_q = mem[ram_a[11:2]];
    always @(posedge CLK) if (ram_we) mem[ram_a[11:2]] <= ram_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every RAM write and every read response is matched in order.
    always @(negedge CLK) begin
        if (!RST) begin
            if (ram_we) begin
                if (wr_q.size() == 0) chk("ram_we_unexpected", 32'd1, 32'd0);
                else begin
                    logic [63:0] e;
                    e = wr_q.pop_front();
                    chk("ram_wr_addr", ram_a, e[63:32]);
                    chk("ram_wr_data", ram_d, e[31:0]);
                end
            end
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 32'd1, 32'd0);
                else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
            end
            if (pim_rvalid) begin
                if (pim_q.size() == 0) chk("pim_rvalid_unexpected", 32'd1, 32'd0);
                else chk("pim_rdata", pim_rdata, pim_q.pop_front());
            end
        end
    end

    task automatic cpu_access(input logic we, input logic [31:0] a, input logic [31:0] d);
        int w;
        @(posedge CLK); #1;
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        if (we) begin
            wr_q.push_back({a & ~32'd3, d});
            model[a[11:2]] = d;
        end else begin
            cpu_q.push_back(model[a[11:2]]);
        end
        w = 0;
        @(negedge CLK);
        while (!cpu_gnt && w < 50) begin
            @(negedge CLK);
            w++;
        end
        chk("cpu_gnt", cpu_gnt, 1'b1);
        @(posedge CLK); #1;
        cpu_req = 1'b0;
        @(negedge CLK);
        chk("cpu_rvalid_timing", cpu_rvalid, !we);
    endtask

    task automatic pim_start(input logic we, input logic [31:0] base, input logic [7:0] len);
        @(posedge CLK); #1;
        pim_req = 1'b1; pim_we = we; pim_addr = base; pim_len = len; pim_wdata = 32'd1;
        @(posedge CLK); #1;
        pim_req = 1'b0;
    endtask

    // Follows a burst to pim_done; pre_at >= 0 means a CPU request is pending and
    // must be granted after exactly pre_at PIM beats.
    task automatic burst_loop(input logic [31:0] base, input int exp_cyc, input int pre_at);
        int beats;
        int done_c;
        bit gnt_seen;
        beats = 0; done_c = -1; gnt_seen = 1'b0;
        for (int c = 0; c < 300 && done_c < 0; c++) begin
            @(negedge CLK);
            if (pim_done) begin
                done_c = c;
                if (!cpu_gnt) chk("done_idle_addr", ram_a, 32'd0);
            end else if (cpu_gnt) begin
                if (!gnt_seen && pre_at >= 0) chk("preempt_after_beats", beats, pre_at);
                gnt_seen = 1'b1;
            end else begin
                chk("pim_beat_addr", ram_a, base + 32'(4 * beats));
                beats++;
            end
            @(posedge CLK); #1;
            if (gnt_seen) cpu_req = 1'b0;
            pim_wdata = 32'(beats + 1);
        end
        chk("pim_done_cycle", done_c, exp_cyc);
        if (pre_at >= 0) chk("cpu_gnt_seen", gnt_seen, 1'b1);
        @(negedge CLK);
        chk("pim_done_single", pim_done, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]   = 32'h1000_0000 + 32'(i * 7);
            model[i] = 32'h1000_0000 + 32'(i * 7);
        end
        RST = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        pim_req = 0; pim_we = 0; pim_addr = '0; pim_len = '0; pim_wdata = '0;
        #12;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_pim_rvalid", pim_rvalid, 0);
        chk("rst_pim_rdata", pim_rdata, 0);
        chk("rst_pim_done", pim_done, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_a", ram_a, 0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Uncontended CPU store then load
        cpu_access(1'b1, 32'h100, 32'hDEADBEEF);
        cpu_access(1'b0, 32'h100, 32'h0);

        // PIM write burst, then CPU readback
        for (int k = 0; k < 4; k++) begin
            wr_q.push_back({32'h200 + 32'(4 * k), 32'(k + 1)});
            model[128 + k] = 32'(k + 1);
        end
        pim_start(1'b1, 32'h200, 8'd4);
        burst_loop(32'h200, 4, -1);
        cpu_access(1'b0, 32'h20C, 32'h0);

        // PIM read burst
        for (int k = 0; k < 4; k++) pim_q.push_back(model[128 + k]);
        pim_start(1'b0, 32'h200, 8'd4);
        burst_loop(32'h200, 4, -1);

        // Preemption: CPU load waiting from beat 0 of a 40-beat read
        for (int k = 0; k < 40; k++) pim_q.push_back(model[256 + k]);
        pim_start(1'b0, 32'h400, 8'd40);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        cpu_q.push_back(model[64]);
        burst_loop(32'h400, 41, 16);

        // Zero-length burst
        pim_start(1'b1, 32'h600, 8'd0);
        burst_loop(32'h600, 0, -1);

        // Reset in beat 3 of a 10-beat write
        for (int k = 0; k < 3; k++) begin
            wr_q.push_back({32'h300 + 32'(4 * k), 32'(k + 1)});
            model[192 + k] = 32'(k + 1);
        end
        pim_start(1'b1, 32'h300, 8'd10);
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            pim_wdata = 32'(k + 2);
        end
        RST = 1'b1;
        cpu_req = 1'b1;
        #1;
        chk("abort_ram_we", ram_we, 0);
        chk("abort_ram_a", ram_a, 0);
        chk("abort_wready", pim_wready, 0);
        chk("abort_cpu_gnt", cpu_gnt, 0);
        chk("abort_pim_done", pim_done, 0);
        cpu_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            chk("abort_no_done", pim_done, 0);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr_q.push_back({32'h500 + 32'(4 * k), 32'(k + 1)});
            model[320 + k] = 32'(k + 1);
        end
        pim_start(1'b1, 32'h500, 8'd2);
        burst_loop(32'h500, 2, -1);

        // Same-cycle tie in IDLE
        @(posedge CLK); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        cpu_q.push_back(model[64]);
        pim_req = 1'b1; pim_we = 1'b0; pim_addr = 32'h200; pim_len = 8'd2;
        for (int k = 0; k < 2; k++) pim_q.push_back(model[128 + k]);
        @(negedge CLK);
        chk("tie_cpu_gnt", cpu_gnt, 1'b1);
        chk("tie_cpu_addr", ram_a, 32'h100);
        @(posedge CLK); #1;
        cpu_req = 1'b0; pim_req = 1'b0;
        burst_loop(32'h200, 2, -1);

        repeat (3) @(negedge CLK);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("pim_q_drained", pim_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port data RAM (combinational read, synchronous write, word-aligned byte address) between two requesters:
  - CPU load/store unit: single-beat accesses.
  - PIM matmul engine: incrementing word bursts.
- Sits between both requesters and the RAM's D/Q/A/WE pins.
- Bounds PIM burst hold time so the CPU is never starved.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width.
- LEN_W, 8, burst-length field width.
- MAX_HOLD, 16, max consecutive PIM beats while the CPU waits.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_wdata  in  DATA_W  store data.
- cpu_gnt  out  1  access performed this cycle.
- cpu_rvalid  out  1  load data valid; one cycle after a load grant.
- cpu_rdata  out  DATA_W  registered load data.
- pim_req  in  1  burst request; sampled only in IDLE.
- pim_we  in  1  burst direction (1 = write).
- pim_addr  in  ADDR_W  burst base byte address.
- pim_len  in  LEN_W  beat count.
- pim_wdata  in  DATA_W  write data for the current beat.
- pim_wready  out  1  write beat consumed this cycle.
- pim_rvalid  out  1  read beat data valid, in beat order.
- pim_rdata  out  DATA_W  registered read data.
- pim_done  out  1  one-cycle pulse when the burst has completed.
- ram_a  out  ADDR_W  RAM address.
- ram_d  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_q  in  DATA_W  RAM read data (combinational from ram_a).

Behaviour:
- Reset (asynchronous, RST high):
  - state = IDLE; all counters = 0.
  - Outputs cpu_gnt, cpu_rvalid, pim_wready, pim_rvalid, pim_done, ram_we are 0.
  - Outputs cpu_rdata, pim_rdata are 0.
  - RST mid-burst aborts the burst; no pim_done is issued.
- Mux: ram_a, ram_d and ram_we come from the current owner. With no owner, ram_we = 0 and ram_a = 0.
- States: IDLE, BURST, DONE.
- IDLE:
  - cpu_req gives a CPU beat the same cycle: cpu_gnt = 1, ram_* = cpu_*.
  - Else pim_req with pim_len != 0: latch base, len and we; go to BURST (first beat next cycle).
  - pim_req with pim_len == 0: pulse pim_done next cycle and touch no RAM.
  - CPU wins any IDLE tie.
- BURST, beat k:
  - ram_a = base + 4*k.
  - Write burst: ram_d = pim_wdata, ram_we = 1, pim_wready = 1.
  - Read burst: pim_rvalid = 1 next cycle, carrying ram_q.
  - After beat len-1, go to DONE.
  - Preemption: hold_cnt counts consecutive PIM beats with cpu_req high. When it reaches MAX_HOLD, the next cycle is a CPU beat: cpu_gnt = 1, no PIM beat, and hold_cnt clears. The burst then resumes at beat k unchanged.
  - hold_cnt clears whenever cpu_req is low.
- DONE: pim_done = 1 for one cycle, then IDLE. A cpu_req in DONE is granted that same cycle.
- Load response: cpu_rdata <= ram_q on a granted load; cpu_rvalid = 1 the following cycle. Stores produce no rvalid.
- Latency:
  - CPU, uncontended: grant at cycle 0, data at cycle 1.
  - CPU during a burst: worst-case wait is MAX_HOLD cycles.
- Address arithmetic is modulo 2^ADDR_W; a burst may wrap silently.
- pim_req is ignored outside IDLE.
- Input changes to cpu_* while not granted are allowed.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, BURST, DONE};
  - owner encoding {OWN_NONE, OWN_CPU, OWN_PIM};
  - WORD_BYTES = 4.
- One natural sub-module, burst_addr_gen: latches base and len; outputs beat address, last-beat flag and beat index. Advances on a step input.
- Arbitration FSM and mux stay in the top module.

Test Plan:
1. Uncontended CPU traffic: CPU store 0xDEADBEEF to 0x100, then load from 0x100.
   -> cpu_gnt in both request cycles; cpu_rvalid one cycle after the load grant with cpu_rdata = 0xDEADBEEF.
2. PIM write burst, then CPU readback: PIM write, base 0x200, len 4, wdata 1,2,3,4; idle CPU.
   -> ram_we for 4 consecutive cycles at 0x200, 0x204, 0x208, 0x20C; pim_done one cycle after the last beat.
   -> CPU loads of 0x20C then return 4.
3. PIM read burst: 4 beats from 0x200.
   -> pim_rvalid for 4 consecutive cycles, data 1,2,3,4; pim_done once.
4. Preemption: MAX_HOLD = 16, PIM read len 40, cpu_req held from beat 0.
   -> cpu_gnt after exactly 16 PIM beats; burst resumes at beat 16; all 40 pim_rdata values arrive in order.
5. Zero length and reset abort:
   -> pim_len = 0: pim_done pulse with no ram_we and no address activity.
   -> RST asserted at beat 3 of a len-10 write: all outputs are 0 immediately; no pim_done; next pim_req starts cleanly at its own base.
6. Same-cycle tie in IDLE: cpu_req and pim_req both rise.
   -> cpu_gnt that cycle; burst beat 0 issues the next cycle.
